// File: rtl/nios2_system_pio_irq_gen2.sv
// Avalon-MM parallel I/O port with edge-capture interrupts.
// Inputs pass a two-flop synchronizer and an optional debounce filter
// (enabled by defining PIO_DEBOUNCE_EN); rising/falling edges of the
// filtered value are latched into EDGECAPTURE and masked onto irq.
// Register map: 0 DATA, 1 OUT, 2 IRQMASK, 3 EDGECAPTURE (W1C),
// 4 RISE_EN, 5 FALL_EN, 6 OUTSET, 7 OUTCLR.
module nios2_system_pio_irq_gen2 #(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] filt, filt_d;
  logic [WIDTH-1:0] out_reg, irq_mask, edge_cap, rise_en, fall_en;
  logic [WIDTH-1:0] evt, ec_clr;
  logic [WIDTH-1:0] rd_mux;
  logic             unused_ok;

  assign wr_en = chipselect & write;
  assign wd    = writedata[WIDTH-1:0];

  // Upper write-data bits and, without debounce, the debounce length are unused.
  assign unused_ok = &{1'b0, writedata, 16'(DEBOUNCE_CYCLES)};

  // Two-flop synchronizer for the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] db_cnt [WIDTH];

  // Per-bit debounce: filt follows s2 only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] != filt[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            filt[i]   <= s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign filt = s2;
`endif

  // Delayed copy of the filtered inputs for edge detection.
  always_ff @(posedge clk) begin
    if (reset) filt_d <= '0;
    else       filt_d <= filt;
  end

  assign evt    = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
  assign ec_clr = (wr_en && address == 3'd3) ? wd : '0;

  // Control registers and edge capture; a new event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg  <= RESET_OUT;
      irq_mask <= '0;
      edge_cap <= '0;
      rise_en  <= '1;
      fall_en  <= '0;
    end else begin
      edge_cap <= (edge_cap & ~ec_clr) | evt;
      if (wr_en) begin
        case (address)
          3'd1: out_reg  <= wd;
          3'd2: irq_mask <= wd;
          3'd4: rise_en  <= wd;
          3'd5: fall_en  <= wd;
          3'd6: out_reg  <= out_reg | wd;
          3'd7: out_reg  <= out_reg & ~wd;
          default: ;
        endcase
      end
    end
  end

  // Read mux of the addressed register.
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = filt;
      3'd1: rd_mux = out_reg;
      3'd2: rd_mux = irq_mask;
      3'd3: rd_mux = edge_cap;
      3'd4: rd_mux = rise_en;
      3'd5: rd_mux = fall_en;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, one-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= 32'(rd_mux);
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios2_system_pio_irq_gen2.sv
// Self-checking bench for nios2_system_pio_irq_gen2. Default build is
// checked cycle-by-cycle against a register-level reference model;
// with PIO_DEBOUNCE_EN the debounce pulse behaviour is checked directly.
module tb_nios2_system_pio_irq_gen2;

  localparam int         W       = 8;
  localparam logic [7:0] RST_OUT = 8'h5A;
  localparam int         DEB     = 16;

  logic        clk = 1'b0;
  logic        reset, chipselect, write;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [W-1:0] in_port, out_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  m_out, m_mask, m_ec, m_rise, m_fall;
  logic [31:0] m_rd;
  logic [7:0]  hist [3];   // inputs seen before the last three edges, newest first
  logic [7:0]  cur_in;

  always #5 clk = ~clk;

  nios2_system_pio_irq_gen2 #(
    .WIDTH(W), .RESET_OUT(RST_OUT), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = RST_OUT; m_mask = '0; m_ec = '0; m_rise = 8'hFF; m_fall = '0;
    m_rd  = '0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // Apply one cycle of inputs at the falling edge, advance the model,
  // then compare the DUT at the next falling edge.
  task automatic step(input logic cs, input logic we, input logic [2:0] a,
                      input logic [31:0] wd, input logic [7:0] inp, input logic rst);
    logic [7:0] filt_now, filt_old, evt, clr, w8;
    logic       wr;
    chipselect = cs; write = we; address = a; writedata = wd; in_port = inp; reset = rst;
    if (rst) begin
      model_reset();
    end else begin
      w8       = wd[7:0];
      wr       = cs & we;
      filt_now = hist[1];
      filt_old = hist[2];
      evt = (filt_now & ~filt_old & m_rise) | (~filt_now & filt_old & m_fall);
      case (a)
        3'd0: m_rd = {24'd0, filt_now};
        3'd1: m_rd = {24'd0, m_out};
        3'd2: m_rd = {24'd0, m_mask};
        3'd3: m_rd = {24'd0, m_ec};
        3'd4: m_rd = {24'd0, m_rise};
        3'd5: m_rd = {24'd0, m_fall};
        default: m_rd = '0;
      endcase
      clr  = (wr && a == 3'd3) ? w8 : 8'h00;
      m_ec = (m_ec & ~clr) | evt;
      if (wr) begin
        case (a)
          3'd1: m_out  = w8;
          3'd2: m_mask = w8;
          3'd4: m_rise = w8;
          3'd5: m_fall = w8;
          3'd6: m_out  = m_out | w8;
          3'd7: m_out  = m_out & ~w8;
          default: ;
        endcase
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = inp;
    end
    @(posedge clk);
    @(negedge clk);
`ifndef PIO_DEBOUNCE_EN
    check("out_port", {24'd0, out_port}, {24'd0, m_out});
    check("readdata", readdata, m_rd);
    check("irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, cur_in, 1'b0);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d, cur_in, 1'b0);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    step(1'b1, 1'b0, a, 32'd0, cur_in, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_rd;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0;
    writedata = '0; in_port = '0; cur_in = '0;
    model_reset();
    @(negedge clk);
    step(1'b0, 1'b0, 3'd0, 32'd0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 3'd0, 32'd0, 8'h00, 1'b1);

    // reset values of all eight addresses
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a));
      exp_rd = (a == 1) ? 32'(RST_OUT) : (a == 4) ? 32'hFF : 32'h0;
      check("reset_read", readdata, exp_rd);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

`ifndef PIO_DEBOUNCE_EN
    // rising edge on bit 0 raises irq exactly three edges after the change
    wr_reg(3'd2, 32'h01);
    cur_in = 8'h01;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("irq_latency", {31'd0, irq}, (i == 2) ? 32'd1 : 32'd0);
    end
    rd_reg(3'd3);
    check("ec_bit0", readdata, 32'h01);
    wr_reg(3'd3, 32'h01);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // falling-only capture on bit 2
    wr_reg(3'd4, 32'h00);
    wr_reg(3'd5, 32'h04);
    cur_in = 8'h05; idle(4);
    wr_reg(3'd3, 32'hFF);
    cur_in = 8'h01; idle(4);
    rd_reg(3'd3);
    check("fall_capture", readdata, 32'h04);
    wr_reg(3'd3, 32'hFF);
    cur_in = 8'h05; idle(4);
    rd_reg(3'd3);
    check("rise_ignored", readdata, 32'h00);

    // clear and new event on bit 1 in the same cycle: event wins
    wr_reg(3'd5, 32'h00);
    wr_reg(3'd4, 32'h02);
    cur_in = 8'h07; idle(4);
    cur_in = 8'h05; idle(4);
    cur_in = 8'h07;
    idle(2);
    wr_reg(3'd3, 32'h02);
    rd_reg(3'd3);
    check("clear_vs_event", readdata & 32'h02, 32'h02);

    // OUTSET / OUTCLR
    wr_reg(3'd1, 32'h0F);
    wr_reg(3'd6, 32'h30);
    check("outset", {24'd0, out_port}, 32'h3F);
    wr_reg(3'd7, 32'h03);
    check("outclr", {24'd0, out_port}, 32'h3C);

    // reset during a write wins; no spurious edge after release with in_port low
    cur_in = 8'h00;
    step(1'b1, 1'b1, 3'd1, 32'hFF, cur_in, 1'b1);
    check("reset_over_write", {24'd0, out_port}, 32'(RST_OUT));
    idle(4);
    rd_reg(3'd3);
    check("no_spurious_edge", readdata, 32'h00);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic cs, we, rst;
      cs  = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) cur_in = 8'($urandom);
      step(cs, we, 3'($urandom_range(0, 7)), $urandom, cur_in, rst);
    end
`else
    // short glitch is rejected
    cur_in = 8'h08;
    for (int i = 0; i < 5; i++) begin
      rd_reg(3'd0);
      check("glitch_data", readdata & 32'h08, 32'h0);
    end
    cur_in = 8'h00;
    for (int i = 0; i < 30; i++) begin
      rd_reg(3'd0);
      check("glitch_data", readdata & 32'h08, 32'h0);
    end
    rd_reg(3'd3);
    check("glitch_capture", readdata, 32'h0);
    // long pulse passes the filter
    cur_in = 8'h08;
    for (int i = 0; i < 40; i++) rd_reg(3'd0);
    rd_reg(3'd0);
    check("pulse_data", readdata, 32'h08);
    rd_reg(3'd3);
    check("pulse_capture", readdata, 32'h08);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_system_pio_irq_gen2.md
NIOS2_SYSTEM_PIO_IRQ_GEN2 -- requirements
Module: nios2_system_pio_irq_gen2

Interface
REQ-001 Parameter WIDTH, default 8, number of input/output bits; legal range 1..32.
REQ-002 Parameter RESET_OUT, default 0, WIDTH-bit reset value of the output register.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, stable-cycle count for the debounce filter; legal range 2..65535.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 chipselect  input  1  Avalon slave select.
REQ-007 address  input  3  register index 0..7.
REQ-008 write  input  1  active-high write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-010 readdata  output  32  registered read data; bits above WIDTH-1 read 0.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 out_port  output  WIDTH  output register contents.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 Register map: 0 DATA (RO, filtered inputs); 1 OUT (RW); 2 IRQMASK (RW); 3 EDGECAPTURE (R, write-1-to-clear); 4 RISE_EN (RW); 5 FALL_EN (RW); 6 OUTSET (WO, 1 sets OUT bits); 7 OUTCLR (WO, 1 clears OUT bits).
REQ-015 Write occurs on a rising clk edge with chipselect=1 and write=1; writes to address 0 have no effect.
REQ-016 readdata is the zero-extended mux of the addressed register, registered every cycle: one-cycle read latency. Addresses 6 and 7 read 0.
REQ-017 in_port passes a two-flop synchronizer (s1, s2) before any use.
REQ-018 Filtered value filt feeds DATA and edge detection; a delayed copy filt_d is registered each cycle.
REQ-019 Rising event bit i = filt[i] & ~filt_d[i] & RISE_EN[i]; falling event = ~filt[i] & filt_d[i] & FALL_EN[i].
REQ-020 An event sets EDGECAPTURE[i] on the next clk edge; the bit stays set until cleared.
REQ-021 Writing 1 to EDGECAPTURE bit i clears it; writing 0 leaves it unchanged.
REQ-022 Same-cycle clear and new event on bit i: event wins, bit remains 1.
REQ-023 irq = OR over (EDGECAPTURE & IRQMASK), combinational from registers, no additional latency.
REQ-024 Latency without debounce: in_port transition stable before edge k -> EDGECAPTURE set and irq high (if unmasked) after edge k+2.
REQ-025 OUTSET/OUTCLR apply only bits written 1: OUT <= OUT | wd, or OUT <= OUT & ~wd.
REQ-026 out_port = OUT directly; OUT write visible on out_port the cycle after the write edge.
REQ-027 Changing IRQMASK affects irq immediately; no pending EDGECAPTURE bits are lost.

Reset
REQ-028 On reset: OUT=RESET_OUT, IRQMASK=0, EDGECAPTURE=0, RISE_EN=all ones, FALL_EN=0, readdata=0, irq=0.
REQ-029 On reset: s1, s2, filt, filt_d = 0; debounce counters = 0.
REQ-030 A reset asserted mid-operation overrides all writes and events in that cycle; no spurious event on reset release while in_port=0.

Configuration
REQ-031 Macro PIO_DEBOUNCE_EN defined: per bit, a counter increments while s2[i] != filt[i] and clears when they match; filt[i] takes s2[i] when the counter reaches DEBOUNCE_CYCLES-1; the counter then clears.
REQ-032 With PIO_DEBOUNCE_EN defined, added latency equals DEBOUNCE_CYCLES cycles; glitches shorter than DEBOUNCE_CYCLES cycles never change filt.
REQ-033 Macro undefined: filt = s2 combinationally; no counters are synthesised; DEBOUNCE_CYCLES is ignored.

Verification
REQ-034 Reset, then read all 8 addresses -> OUT=RESET_OUT, RISE_EN=0xFF, all others 0; irq=0.
REQ-035 IRQMASK=0x01; in_port[0] 0->1 -> EDGECAPTURE=0x01 and irq=1 exactly 3 edges after the change; write 0x01 to addr 3 -> irq=0 next cycle.
REQ-036 FALL_EN=0x04, RISE_EN=0x00; toggle in_port[2] 1->0 -> EDGECAPTURE=0x04; toggle 0->1 -> no new capture.
REQ-037 With EDGECAPTURE[1]=1, write 0x02 to addr 3 in the same cycle as a new rising event on bit 1 -> EDGECAPTURE[1] stays 1.
REQ-038 OUT=0x0F; write 0x30 to addr 6 then 0x03 to addr 7 -> out_port=0x3F then 0x3C.
REQ-039 PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 5-cycle pulse on in_port[3] -> DATA unchanged, no capture; 40-cycle pulse -> DATA bit 3 set, EDGECAPTURE=0x08.
